serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial add/subtract unit built around a single `fac` full-adder cell, which is its only arithmetic element. A controller FSM accepts W-bit operands on a start pulse. It feeds the cell one bit pair per clock, LSB first, and keeps the carry in a flip-flop between bits. It then returns a registered W-bit result with carry-out and signed overflow flags. The block trades latency for area: the lab datapath gets a W-bit adder from one cell.

## Interface
- `W`, default 8: operand and result width in bits; legal range W ≥ 2.

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `start`: input, 1 bit. Request a new operation; sampled on the rising edge.
- `sub`: input, 1 bit. 0 selects a+b, 1 selects a−b; sampled together with `start`.
- `a`: input, W bits. First operand; sampled with `start`.
- `b`: input, W bits. Second operand; sampled with `start`.
- `busy`: output, 1 bit. High while the FSM is in RUN.
- `done`: output, 1 bit. One-cycle pulse; high while in DONE.
- `sum`: output, W bits. Registered result.
- `cout`: output, 1 bit. Carry out of the MSB; for subtraction 1 means no borrow (a ≥ b unsigned).
- `ovf`: output, 1 bit. Two's-complement overflow.

## Operation
- **States:** IDLE, RUN, DONE, binary encoded. Internal registers:
  - operand shift registers `ra` and `rb`, W bits each;
  - result shift register `rs`, W bits;
  - carry flip-flop `c`;
  - bit counter `cnt`, ⌈log2 W⌉ bits;
  - `c_msb`, the carry into the MSB.
- **IDLE:** `start`=1 loads `ra`←a, `rb`←(sub ? ~b : b), `c`←sub, `cnt`←0, then moves to RUN. `start`=0 stays in IDLE.
- **RUN, every cycle:** the `fac` inputs are x=`ra[0]`, y=`rb[0]`, ci=`c`.
  - `rs` shifts right with the cell's z entering the MSB.
  - `ra` and `rb` shift right.
  - `c`←co.
  - `cnt`←`cnt`+1.
  - When `cnt`=W−2, `c_msb`←co. This captures the carry into bit W−1.
- **RUN exit:** on the cycle where `cnt`=W−1, the FSM goes to DONE and loads the outputs:
  - `sum`←{z, `rs[W−1:1]`};
  - `cout`←co;
  - `ovf`←co ^ `c_msb`.
- **DONE:** `done`=1 for exactly one cycle.
  - `start`=1 in this cycle is accepted exactly as in IDLE and goes straight to RUN (back-to-back operation).
  - Otherwise the FSM returns to IDLE.
- **Result holding:** `sum`, `cout` and `ovf` change only on entry to DONE. They hold the previous result through IDLE and through the whole next RUN.
- **Start while busy:** `start` during RUN is ignored. Operands and `sub` are not re-sampled.
- **Arithmetic:** modulo 2^W. Subtraction is a + ~b + 1, using the carry flip-flop preset as the +1.
- **Reset:** `rst`=1 wins over every other input, including mid-RUN (the operation is aborted and never reported). Reset values:
  - state=IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0;
  - `c`=0, `cnt`=0.

## Timing
- **Start to done:** `start` sampled at edge E0 → RUN during cycles 1..W → `done`=1 in cycle W+1. Latency from start to done is W+1 clocks.
- **Result timing:** `sum`, `cout` and `ovf` are valid in the same cycle `done` is high, and stay valid afterwards.
- **Throughput:** one operation per W+1 cycles, achieved when `start` is asserted in each DONE cycle.
- **Busy:** `busy`=1 for exactly W consecutive cycles per operation.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **Reset timing:** `rst` asserted at edge R puts all outputs at reset values from R onward. The first `start` can be accepted at the edge after `rst` is deasserted.

## Test plan
- **W=8 additions, one operation each:**
  - 100+27 → `sum`=127, `cout`=0, `ovf`=0.
  - 200+100 → `sum`=44, `cout`=1, `ovf`=0.
  - 127+1 → `sum`=128, `ovf`=1, `cout`=0.
- **W=8 subtractions:**
  - 5−7 → `sum`=254, `cout`=0, `ovf`=0.
  - 128−1 → `sum`=127, `cout`=1, `ovf`=1.
  - 9−9 → `sum`=0, `cout`=1.
- **Handshake timing:** count cycles from the `start` edge to `done`; it must be 9 for W=8.
  - `busy` high for exactly 8 cycles.
  - `done` high for exactly 1 cycle.
  - `sum` keeps its previous value during RUN.
- **Start during RUN:** pulse `start` with new operands in cycle 3 of RUN → it is ignored, and the original result appears at the original time.
  - Then assert `start` in the DONE cycle → a second result appears 9 cycles later with no IDLE cycle in between.
- **Reset mid-RUN:** assert `rst` in cycle 4 of RUN → all outputs are 0 at the next edge and no `done` pulse occurs.
  - A following 3+4 → `sum`=7.
- **Exhaustive at W=3:** all 64 (a,b) pairs for both values of `sub`, compared against a reference model of `sum`, `cout` and `ovf`, checked on each `done` pulse.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full-adder cell processes one bit pair
// per clock, LSB first, with the carry held in a flip-flop between bits.
// A small FSM loads the operands, runs W bit-steps and presents a registered
// result with carry-out and signed overflow for exactly one DONE cycle.

// Single-bit full adder; the only arithmetic element of the datapath.
module fac (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic z,
  output logic co
);
  assign z  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_MSB  = CW'(W - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    ra_q, ra_d;
  logic [W-1:0]    rb_q, rb_d;
  // The result register keeps only the W-1 partial bits already produced;
  // the last bit comes straight from the cell on the exit cycle.
  logic [W-2:0]    rs_q, rs_d;
  logic            c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            c_msb_q, c_msb_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic            fa_z;
  logic            fa_co;
  logic [W-1:0]    rs_full;

  fac u_fac (
    .x  (ra_q[0]),
    .y  (rb_q[0]),
    .ci (c_q),
    .z  (fa_z),
    .co (fa_co)
  );

  // Result register contents after this cycle's shift, with the new bit at the MSB.
  assign rs_full = {fa_z, rs_q};

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    c_msb_d = c_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // Subtraction is a + ~b + 1: invert b here and preset the carry as the +1.
          ra_d    = a;
          rb_d    = sub ? ~b : b;
          c_d     = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        rs_d  = rs_full[W-1:1];
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        c_d   = fa_co;
        cnt_d = cnt_q + 1'b1;
        // Carry into the sign bit, needed for the overflow flag.
        if (cnt_q == CNT_MSB) begin
          c_msb_d = fa_co;
        end
        if (cnt_q == CNT_LAST) begin
          sum_d   = rs_full;
          cout_d  = fa_co;
          ovf_d   = fa_co ^ c_msb_q;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers with synchronous reset; reset aborts any running operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Shift registers are always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    ra_q    <= ra_d;
    rb_q    <= rb_d;
    rs_q    <= rs_d;
    c_msb_q <= c_msb_d;
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: a W=8 instance for directed
// vectors and handshake timing, and a W=3 instance swept over all inputs.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       rst3, start3, sub3, busy3, done3, cout3, ovf3;
  logic [2:0] a3, b3, sum3;

  serial_adder_ctrl #(.W(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.W(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .sub(sub3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
  );

  typedef struct packed { logic [7:0] s; logic c; logic o; } exp8_t;
  typedef struct packed { logic [2:0] s; logic c; logic o; } exp3_t;
  exp8_t q8[$];
  exp3_t q3[$];

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] prev8 = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the W=8 instance: every done pulse consumes one expectation.
  always @(negedge clk) begin
    exp8_t e;
    if (done8 === 1'b1) begin
      chk("pending8", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("sum8", 32'(sum8), 32'(e.s));
        chk("cout8", 32'(cout8), 32'(e.c));
        chk("ovf8", 32'(ovf8), 32'(e.o));
      end
    end
  end

  // Monitor for the W=3 instance.
  always @(negedge clk) begin
    exp3_t e;
    if (done3 === 1'b1) begin
      chk("pending3", 32'(q3.size() > 0), 32'd1);
      if (q3.size() > 0) begin
        e = q3.pop_front();
        chk("sum3", 32'(sum3), 32'(e.s));
        chk("cout3", 32'(cout3), 32'(e.c));
        chk("ovf3", 32'(ovf3), 32'(e.o));
      end
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input bit push, input logic [7:0] es, input logic ec, input logic eo);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    if (push) q8.push_back('{es, ec, eo});
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Called #1 after the start edge; lat counts edges from the start edge to done.
  task automatic wait8(output int lat, output int nbusy, output bit held);
    lat = 1; nbusy = 0; held = 1'b1;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) nbusy++;
      if (sum8 !== prev8) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("done8_seen", 32'(done8 === 1'b1), 32'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo);
    int lat, nb;
    bit held;
    issue8(a, b, s, 1'b1, es, ec, eo);
    wait8(lat, nb, held);
    chk("latency8", 32'(lat), 32'd9);
    chk("busy8_cycles", 32'(nb), 32'd8);
    chk("sum8_held", 32'(held), 32'd1);
    prev8 = es;
    @(posedge clk); #1;
    chk("done8_pulse", 32'({busy8, done8}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, seen;
    bit held;
    rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    rst3 = 1'b1; start3 = 1'b0; sub3 = 1'b0; a3 = '0; b3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst8_state", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
    chk("rst3_state", 32'({busy3, done3, cout3, ovf3, sum3}), 32'd0);
    rst8 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    // Directed additions and subtractions
    run8(8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0);
    run8(8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0);
    run8(8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1);
    run8(8'd5,   8'd7,   1'b1, 8'd254, 1'b0, 1'b0);
    run8(8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1);
    run8(8'd9,   8'd9,   1'b1, 8'd0,   1'b1, 1'b0);

    // Start during RUN is ignored; then back-to-back start in the DONE cycle
    issue8(8'd50, 8'd60, 1'b0, 1'b1, 8'd110, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a8 = 8'd1; b8 = 8'd1; sub8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait8(lat, nb, held);
    chk("ignored_start_latency", 32'(lat), 32'd6);
    chk("ignored_start_busy", 32'(nb), 32'd5);
    chk("ignored_start_held", 32'(held), 32'd1);
    prev8 = 8'd110;
    issue8(8'd10, 8'd20, 1'b1, 1'b1, 8'd246, 1'b0, 1'b0);
    chk("b2b_no_idle", 32'(busy8), 32'd1);
    wait8(lat, nb, held);
    chk("b2b_latency", 32'(lat), 32'd9);
    chk("b2b_busy", 32'(nb), 32'd8);
    chk("b2b_held", 32'(held), 32'd1);
    prev8 = 8'd246;
    @(posedge clk); #1;
    chk("b2b_done_pulse", 32'({busy8, done8}), 32'd0);

    // Reset in cycle 4 of RUN aborts the operation
    issue8(8'd200, 8'd55, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst8 = 1'b1;
    @(posedge clk); #1;
    chk("rst8_midrun", 32'({busy8, done8, cout8, ovf8, sum8}), 32'd0);
    rst8 = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) seen++;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);
    prev8 = 8'd0;
    run8(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0);

    // Exhaustive sweep at W=3 against an integer reference
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 8; ia++) begin
        for (int ib = 0; ib < 8; ib++) begin
          int sa, sb, r, ur;
          int wait_n;
          exp3_t e;
          sa = (ia > 3) ? ia - 8 : ia;
          sb = (ib > 3) ? ib - 8 : ib;
          r  = (s == 1) ? sa - sb : sa + sb;
          ur = (s == 1) ? ia - ib : ia + ib;
          e.s = 3'(ur & 7);
          e.c = (s == 1) ? (ia >= ib) : (ur >= 8);
          e.o = (r > 3) || (r < -4);
          a3 = 3'(ia); b3 = 3'(ib); sub3 = s[0]; start3 = 1'b1;
          q3.push_back(e);
          @(posedge clk); #1;
          start3 = 1'b0;
          wait_n = 0;
          while (done3 !== 1'b1 && wait_n < 12) begin
            @(posedge clk); #1;
            wait_n++;
          end
          if (done3 !== 1'b1) chk("done3_timeout", 32'(wait_n), 32'd3);
          @(posedge clk); #1;
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
